signext_32_unit: RTL and testbench
==================================

// Module: signext_32_unit
// PURPOSE
//  Immediate extender for the MIPS single-cycle datapath: widens the 16-bit instruction
//  immediate to a 32-bit operand for the ALU B-mux and branch-offset adder.
//  Combinational result (extended) feeds the single-cycle datapath with zero latency.
//  A registered copy (extended_q) serves pipelined/debug consumers.
// PARAMETERS
//  IMM_W   16  immediate input width
//  OUT_W   32  extended output width (OUT_W > IMM_W)
// PORTS
//  clk         in   1      system clock, rising edge; sole clock of the block
//  rst         in   1      asynchronous, active-high reset
//  imm         in   16     instruction immediate, imm[15] is the sign bit
//  ext_op      in   2      00 sign-ext, 01 zero-ext, 10 LUI (imm<<16), 11 sign-ext<<2 (branch)
//  load_en     in   1      capture enable for extended_q
//  extended    out  32     combinational extension result
//  extended_q  out  32     registered extension result
//  q_valid     out  1      extended_q holds a captured value since last reset
// BEHAVIOUR
//  - extended is purely combinational from imm/ext_op; no clock, no reset dependence.
//  - ext_op=00: extended = {{16{imm[15]}}, imm}; e.g. f111 -> ffff_f111, 0000 -> 0000_0000.
//  - ext_op=01: extended = {16'h0000, imm}.
//  - ext_op=10: extended = {imm, 16'h0000}.
//  - ext_op=11: extended = {{14{imm[15]}}, imm, 2'b00}; bits shifted out above bit 31 dropped.
//  - Default (power-on / unknown ext_op is X): treat as sign-ext; no latches.
//  - Default-mode result equals a pure 16->32 sign extension of imm.
//  - rst high (async, any time): extended_q <= 0, q_valid <= 0 immediately; extended unaffected.
//  - On posedge clk with rst low and load_en=1: extended_q <= extended, q_valid <= 1.
//    load_en=0: extended_q and q_valid hold. Latency imm->extended_q = 1 cycle.
//  - Reset deasserted mid-stream: first capture on the first posedge where load_en=1.
//  - Changing imm/ext_op in the same cycle as capture: value present before the edge is stored.
//  - No arithmetic carries; pure bit replication/concatenation.
// STRUCTURE
//  - Shared package: ext_op encodings (EXT_SIGN, EXT_ZERO, EXT_LUI, EXT_BR) and IMM_W/OUT_W
//    defaults, also used by the control decoder.
//  - One natural sub-module: signext_core (combinational 16->32 sign extension, ports imm,
//    extended); the top adds the mode mux and the output register.
// TESTING
//  1. ext_op=00, imm=16'hf111 -> extended=32'hffff_f111 within 10 ns, no clock needed.
//  2. ext_op=00, imm=16'h0000 -> extended=32'h0000_0000; imm=16'h8000 -> 32'hffff_8000;
//     imm=16'h7fff -> 32'h0000_7fff.
//  3. imm=16'hf111: ext_op=01 -> 0000_f111; 10 -> f111_0000; 11 -> ffff_c444.
//  4. rst=1 async (no clock) -> extended_q=0, q_valid=0;
//     release, load_en=1, imm=16'h8001, op=00, one posedge -> extended_q=ffff_8001, q_valid=1.
//  5. load_en=0, imm changes to 16'h1234 over 3 clocks -> extended_q holds ffff_8001;
//     extended tracks 0000_1234.
//  6. Assert rst between clock edges while extended_q=ffff_8001 -> extended_q clears before
//     next edge; extended unchanged.

Source files
------------

// File: rtl/signext_32_unit_pkg.sv
// Shared immediate-extension definitions: ext_op encodings and default widths.
// The control decoder imports this package as well.
package signext_32_unit_pkg;

  localparam int unsigned IMM_W_DEF = 16;
  localparam int unsigned OUT_W_DEF = 32;

  typedef enum logic [1:0] {
    EXT_SIGN = 2'b00,
    EXT_ZERO = 2'b01,
    EXT_LUI  = 2'b10,
    EXT_BR   = 2'b11
  } ext_op_e;

endpackage : signext_32_unit_pkg

// File: rtl/signext_32_unit_core.sv
// Plain IMM_W -> OUT_W sign extension by replicating the immediate's top bit.
module signext_core #(
  parameter int unsigned IMM_W = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IMM_W-1:0] imm,
  output logic [OUT_W-1:0] extended
);

  assign extended = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};

endmodule : signext_core

// File: rtl/signext_32_unit.sv
// Immediate extender: combinational mode mux over the sign-extend core, plus a
// capture register with a valid flag for pipelined/debug consumers.
module signext_32_unit
  import signext_32_unit_pkg::*;
#(
  parameter int unsigned IMM_W = IMM_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       ext_op,
  input  logic             load_en,
  output logic [OUT_W-1:0] extended,
  output logic [OUT_W-1:0] extended_q,
  output logic             q_valid
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_mux;
  logic [OUT_W-1:0] ext_q_d, ext_q_q;
  logic             valid_d, valid_q;

  signext_core #(
    .IMM_W (IMM_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm      (imm),
    .extended (sext)
  );

  // Unknown ext_op falls into default so the datapath sees a sign extension.
  always_comb begin
    ext_mux = sext;
    case (ext_op_e'(ext_op))
      EXT_SIGN: ext_mux = sext;
      EXT_ZERO: ext_mux = OUT_W'(imm);
      EXT_LUI:  ext_mux = OUT_W'(imm) << IMM_W;
      EXT_BR:   ext_mux = sext << 2;
      default:  ext_mux = sext;
    endcase
  end

  assign extended = ext_mux;

  always_comb begin
    ext_q_d = ext_q_q;
    valid_d = valid_q;
    if (load_en) begin
      ext_q_d = ext_mux;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ext_q_q <= ext_q_d;
      valid_q <= valid_d;
    end
  end

  assign extended_q = ext_q_q;
  assign q_valid    = valid_q;

endmodule : signext_32_unit

// File: tb/tb_signext_32_unit.sv
// Scoreboard bench for signext_32_unit: directed corner cases, then random
// stimulus with async reset pulses, checked against an arithmetic model.
module tb_signext_32_unit;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [15:0] imm;
  logic [1:0]  ext_op;
  logic        load_en;
  logic [31:0] extended;
  logic [31:0] extended_q;
  logic        q_valid;

  int unsigned total;
  int unsigned bad;
  logic [31:0] exp_q_fifo[$];

  signext_32_unit #(
    .IMM_W (16),
    .OUT_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imm        (imm),
    .ext_op     (ext_op),
    .load_en    (load_en),
    .extended   (extended),
    .extended_q (extended_q),
    .q_valid    (q_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = clk_en ? ~clk : clk;
  end

  // Reference: interpret imm as a signed integer and scale it arithmetically.
  function automatic logic [31:0] ref_ext(input logic [15:0] i, input logic [1:0] op);
    int s;
    s = (i >= 16'h8000) ? int'(i) - 65536 : int'(i);
    case (op)
      2'd1:    return 32'(int'(i));
      2'd2:    return 32'(int'(i)) * 32'd65536;
      2'd3:    return 32'(s * 4);
      default: return 32'(s);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: owns the expected register state, pops on every capture edge.
  initial begin : monitor
    logic [31:0] exp_q;
    logic        exp_v;
    logic        cap;
    exp_q = '0;
    exp_v = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q = '0;
        exp_v = 1'b0;
        #1;
        chk("rst_q", extended_q, exp_q);
        chk("rst_valid", 32'(q_valid), 32'(exp_v));
      end else begin
        cap = load_en;
        #1;
        if (cap) begin
          if (exp_q_fifo.size() == 0) begin
            total++;
            bad++;
            $display("FAIL capture_underflow: got capture expected none at %0t", $time);
          end else begin
            exp_q = exp_q_fifo.pop_front();
          end
          exp_v = 1'b1;
        end
        chk(cap ? "capture_q" : "hold_q", extended_q, exp_q);
        chk("q_valid", 32'(q_valid), 32'(exp_v));
      end
    end
  end

  logic [15:0] d_imm[8];
  logic [1:0]  d_op[8];
  logic [31:0] d_exp[8];

  initial begin : driver
    total   = 0;
    bad     = 0;
    clk_en  = 1'b0;
    rst     = 1'b1;
    imm     = '0;
    ext_op  = '0;
    load_en = 1'b0;
    #2;
    chk("por_q", extended_q, 32'h0);
    chk("por_valid", 32'(q_valid), 32'h0);

    d_imm = '{16'hf111, 16'h0000, 16'h8000, 16'h7fff, 16'hf111, 16'hf111, 16'hf111, 16'h0001};
    d_op  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    d_exp = '{32'hffff_f111, 32'h0000_0000, 32'hffff_8000, 32'h0000_7fff,
              32'h0000_f111, 32'hf111_0000, 32'hffff_c444, 32'h0000_0004};
    for (int unsigned k = 0; k < 8; k++) begin
      imm    = d_imm[k];
      ext_op = d_op[k];
      #10;
      chk($sformatf("comb_dir%0d", k), extended, d_exp[k]);
    end

    rst = 1'b0;
    #3;
    clk_en = 1'b1;

    @(negedge clk);
    imm     = 16'h8001;
    ext_op  = 2'd0;
    load_en = 1'b1;
    exp_q_fifo.push_back(32'hffff_8001);

    @(negedge clk);
    load_en = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      imm = 16'h1234;
      #1;
      chk("track_comb", extended, 32'h0000_1234);
      @(negedge clk);
    end

    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midcyc_rst_q", extended_q, 32'h0);
    chk("midcyc_rst_valid", 32'(q_valid), 32'h0);
    chk("midcyc_rst_comb", extended, 32'h0000_1234);
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned n = 0; n < 300; n++) begin
      @(negedge clk);
      imm     = 16'($urandom);
      ext_op  = 2'($urandom_range(0, 3));
      load_en = ($urandom_range(0, 9) < 6);
      if (load_en) exp_q_fifo.push_back(ref_ext(imm, ext_op));
      #1;
      chk("rand_comb", extended, ref_ext(imm, ext_op));
      if ($urandom_range(0, 19) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("fifo_drained", 32'(exp_q_fifo.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_signext_32_unit
